// File: rtl/write_back_block.sv
// write_back_block: registered write-back result for the register file.
// Define WB_DOUBLE_REG_EN to add a second register stage (latency 2 instead of 1).
module write_back_block #(
   parameter int               WIDTH       = 8,
   parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] mux_ans_dm,
   output logic [WIDTH-1:0] ans_wb
);
`ifdef WB_DOUBLE_REG_EN
   logic [WIDTH-1:0] stage1;
   // reset clears both stages so no in-flight value survives it
   always_ff @(posedge clk) begin
      if (!reset) begin
         stage1 <= RESET_VALUE;
         ans_wb <= RESET_VALUE;
      end else begin
         stage1 <= mux_ans_dm;
         ans_wb <= stage1;
      end
   end
`else
   always_ff @(posedge clk)
      ans_wb <= !reset ? RESET_VALUE : mux_ans_dm;
`endif
endmodule

// File: tb/tb_write_back_block.sv
// tb_write_back_block: randomized and directed checks of write_back_block against a
// queue-based pipeline model; latency follows WB_DOUBLE_REG_EN.
`timescale 1ns/1ps
module tb_write_back_block;
`ifdef WB_DOUBLE_REG_EN
   localparam int LAT = 2;
`else
   localparam int LAT = 1;
`endif
   localparam logic [7:0] RV = 8'h00;

   logic       clk;
   logic       reset;
   logic [7:0] mux_ans_dm;
   logic [7:0] ans_wb;
   logic [7:0] hist[$];
   int         total = 0;
   int         bad = 0;

   write_back_block dut (.clk(clk), .reset(reset), .mux_ans_dm(mux_ans_dm), .ans_wb(ans_wb));

   initial begin
      clk = 1'b0;
      forever #500 clk = ~clk;
   end

   // model: each edge shifts the sampled input into a LAT-deep delay line; reset wipes it
   always @(posedge clk) begin
      if (!reset) begin
         hist.delete();
         for (int i = 0; i < LAT; i++) hist.push_back(RV);
      end else begin
         hist.push_front(mux_ans_dm);
         void'(hist.pop_back());
      end
   end

   function automatic logic [7:0] expv();
      return hist[LAT-1];
   endfunction

   task automatic test_reset();
      mux_ans_dm = 8'hFF;
      reset = 1'b1;
      #200 reset = 1'b0;
      #301;
      total++;
      if (ans_wb !== 8'h00) begin bad++; $display("FAIL reset_value got=%h want=%h", ans_wb, 8'h00); end
      #199 reset = 1'b1;
      #700;
      total++;
      if (ans_wb !== 8'h00) begin bad++; $display("FAIL reset_hold got=%h want=%h", ans_wb, 8'h00); end
      #101;
      total++;
      if (ans_wb !== (LAT == 1 ? 8'hFF : 8'h00)) begin
         bad++; $display("FAIL resume_capture got=%h want=%h", ans_wb, (LAT == 1 ? 8'hFF : 8'h00));
      end
      #499 mux_ans_dm = 8'h0F;
      #400;
      total++;
      if (ans_wb !== (LAT == 1 ? 8'hFF : 8'h00)) begin
         bad++; $display("FAIL hold_between_edges got=%h want=%h", ans_wb, (LAT == 1 ? 8'hFF : 8'h00));
      end
      #101;
      total++;
      if (ans_wb !== (LAT == 1 ? 8'h0F : 8'hFF)) begin
         bad++; $display("FAIL new_data got=%h want=%h", ans_wb, (LAT == 1 ? 8'h0F : 8'hFF));
      end
   endtask

   task automatic test_glitch_reset();
      @(negedge clk) mux_ans_dm = 8'hA5;
      repeat (LAT + 1) @(negedge clk);
      total++;
      if (ans_wb !== 8'hA5) begin bad++; $display("FAIL glitch_setup got=%h want=%h", ans_wb, 8'hA5); end
      #100 reset = 1'b0;
      #100 reset = 1'b1;
      #1;
      total++;
      if (ans_wb !== 8'hA5) begin bad++; $display("FAIL glitch_async got=%h want=%h", ans_wb, 8'hA5); end
      @(negedge clk);
      total++;
      if (ans_wb !== 8'hA5) begin bad++; $display("FAIL glitch_edge got=%h want=%h", ans_wb, 8'hA5); end
   endtask

   task automatic test_reset_midstream();
      logic [7:0] want[3];
      want[0] = LAT == 1 ? 8'h12 : 8'hA5;
      want[1] = LAT == 1 ? 8'h34 : 8'h12;
      want[2] = 8'h00;
      mux_ans_dm = 8'h12;
      @(negedge clk) mux_ans_dm = 8'h34;
      total++;
      if (ans_wb !== want[0]) begin bad++; $display("FAIL midstream_0 got=%h want=%h", ans_wb, want[0]); end
      @(negedge clk) begin mux_ans_dm = 8'h56; reset = 1'b0; end
      total++;
      if (ans_wb !== want[1]) begin bad++; $display("FAIL midstream_1 got=%h want=%h", ans_wb, want[1]); end
      @(negedge clk) begin mux_ans_dm = 8'h77; reset = 1'b1; end
      total++;
      if (ans_wb !== want[2]) begin bad++; $display("FAIL midstream_reset got=%h want=%h", ans_wb, want[2]); end
      @(negedge clk);
      total++;
      if (ans_wb !== (LAT == 1 ? 8'h77 : 8'h00)) begin
         bad++; $display("FAIL midstream_resume got=%h want=%h", ans_wb, (LAT == 1 ? 8'h77 : 8'h00));
      end
   endtask

   task automatic test_latency();
      @(negedge clk) reset = 1'b0;
      @(negedge clk) begin reset = 1'b1; mux_ans_dm = 8'h3C; end
      @(negedge clk) mux_ans_dm = 8'h00;
      total++;
      if (ans_wb !== (LAT == 1 ? 8'h3C : 8'h00)) begin
         bad++; $display("FAIL latency_n got=%h want=%h", ans_wb, (LAT == 1 ? 8'h3C : 8'h00));
      end
      @(negedge clk);
      total++;
      if (ans_wb !== (LAT == 1 ? 8'h00 : 8'h3C)) begin
         bad++; $display("FAIL latency_n1 got=%h want=%h", ans_wb, (LAT == 1 ? 8'h00 : 8'h3C));
      end
   endtask

   task automatic test_back_to_back();
      logic [7:0] sent[$];
      logic [7:0] v;
      reset = 1'b1;
      for (int i = 0; i < 24; i++) begin
         @(negedge clk);
         if (i >= LAT + 1) begin
            v = sent[i - LAT];
            total++;
            if (ans_wb !== v) begin bad++; $display("FAIL b2b_%0d got=%h want=%h", i, ans_wb, v); end
         end
         v = 8'($urandom);
         sent.push_back(v);
         mux_ans_dm = v;
      end
   endtask

   task automatic test_random();
      logic [7:0] held;
      for (int i = 0; i < 300; i++) begin
         @(negedge clk);
         total++;
         if (ans_wb !== expv()) begin bad++; $display("FAIL rand_%0d got=%h want=%h", i, ans_wb, expv()); end
         held = ans_wb;
         mux_ans_dm = 8'($urandom);
         reset = ($urandom_range(0, 9) != 0);
         #250 mux_ans_dm = 8'($urandom);
         if ($urandom_range(0, 3) == 0) reset = ~reset;
         #1;
         total++;
         if (ans_wb !== held) begin bad++; $display("FAIL rand_hold_%0d got=%h want=%h", i, ans_wb, held); end
      end
      @(negedge clk) reset = 1'b1;
   endtask

   initial begin
      for (int i = 0; i < LAT; i++) hist.push_back('x);
      test_reset();
      test_glitch_reset();
      test_reset_midstream();
      test_latency();
      test_back_to_back();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
